bram_dp_be: RTL and testbench
=============================

Name: bram_dp_be

Overview:
- Parametrised successor of the single-port control BRAM.
- Two ports: port A read/write with byte enables; port B read-only.
- Configurable read latency (1 or 2 cycles) and a read-during-write collision mode.
- Sits between the core's control/data paths and on-chip block RAM; all logic on the rising edge of one clock.

Parameters:
AW, 10, address width; depth = 2**AW words; must be >= 1
DW, 32, data width; must be a multiple of 8 and >= 8
RD_LAT, 1, read latency in cycles; legal values 1 or 2
WR_FIRST, 0, collision mode: 0 = read-first (old data), 1 = write-first (new merged data)

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst_n  in  1  asynchronous, active-low reset
i_a_addr  in  AW  port A address
i_a_en  in  1  port A access enable
i_a_we  in  DW/8  port A byte write enables; nonzero with i_a_en = write access
i_a_data  in  DW  port A write data
o_a_data  out  DW  port A read data
o_a_valid  out  1  port A read data valid pulse
i_b_addr  in  AW  port B address
i_b_en  in  1  port B read enable
o_b_data  out  DW  port B read data
o_b_valid  out  1  port B read data valid pulse

Behaviour:
- Reset: one clock, i_clk; reset i_rst_n is asynchronous, active-low.
  - Assertion immediately clears o_a_data, o_b_data, o_a_valid, o_b_valid and all internal pipeline registers to 0.
  - In-flight reads are dropped. Memory contents are NOT cleared.
  - While reset is asserted, i_a_en and i_b_en are ignored; no writes occur.
- Memory: zero-initialised at configuration.
- Writes:
  - Port A write commits on the rising edge when i_a_en=1.
  - Only bytes with i_a_we[k]=1 update, bits [8k+7:8k]; other bytes keep their old value.
- Reads:
  - Every enabled access (A read, A write, B read) produces exactly one valid pulse, RD_LAT cycles after the enable edge.
  - RD_LAT=1: data and valid registered at edge N+1.
  - RD_LAT=2: one extra output register stage.
- Back-to-back accesses: fully pipelined; one access per port per cycle; no stalls.
- Output hold: when valid is low, o_*_data holds the last delivered value.
- Port A write return data:
  - WR_FIRST=0: pre-write word.
  - WR_FIRST=1: post-write merged word.
- Collision (A writes address X, B reads X, same edge):
  - WR_FIRST=0: B returns the old word.
  - WR_FIRST=1: B returns the merged new word, via bypass: written bytes from i_a_data, others from memory.
- Address wrap: none needed; addresses are exactly AW bits, and all 2**AW locations are valid.
- Parameter validation: elaboration error if AW<1, DW<8, DW%8!=0, RD_LAT not in {1,2}, or WR_FIRST not in {0,1}.

Optional Feature:
- Macro BRAM_DP_PARITY_EN.
- When defined:
  - Memory stores one even-parity bit per byte, DW + DW/8 bits per word.
  - Extra outputs o_a_perr and o_b_perr (DW/8 bits each) are aligned with valid. Bit k=1 when stored byte k parity mismatches.
  - perr outputs reset to 0. Bypassed bytes never flag an error.
- When undefined: no parity storage and no perr ports; behaviour otherwise identical.

Decomposition:
- Package bram_pkg contains:
  - enum rw_mode_e {READ_FIRST, WRITE_FIRST}
  - function byte_merge(old, new, be)
  - function byte_parity(word)
  - localparam BW = DW/8 helper
- Sub-module bram_out_pipe: parametrised by DW and RD_LAT. Provides valid+data output staging with async reset. Instantiated once per port.

Test Plan:
1. Reset then read: reset, B read addr 0x005, RD_LAT=1 -> o_b_valid at edge+1, o_b_data=0x00000000.
2. Byte-enable write: A write 0xDEADBEEF we=4'b1111 to 0x010, then we=4'b0101 data 0x11223344 -> B read 0x010 returns 0xDE22BE44.
3. Collision: A write 0xAAAAAAAA to 0x020 (holds 0x12345678) with B read 0x020 same edge -> WR_FIRST=0: 0x12345678; WR_FIRST=1: 0xAAAAAAAA.
4. Latency/throughput: RD_LAT=2, B reads 0x000..0x003 on 4 consecutive edges -> 4 consecutive valid pulses starting edge+2, data in order.
5. Mid-op reset: issue A read, assert i_rst_n=0 before data returns -> o_a_valid never pulses; after release, earlier-written data still readable.
6. Parity (BRAM_DP_PARITY_EN): force a flipped stored bit in byte 2 of 0x030 -> read returns o_b_perr=4'b0100 with valid.

Source files
------------

// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - collision-mode enum and per-byte helpers shared by bram_dp_be
package bram_pkg;

  typedef enum logic {
    READ_FIRST  = 1'b0,
    WRITE_FIRST = 1'b1
  } rw_mode_e;

  function automatic int bw_of(input int dw);
    return dw / 8;
  endfunction

  function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       be);
    return be ? new_byte : old_byte;
  endfunction

  // Even parity: the stored bit makes the byte plus parity bit have an even count of ones.
  function automatic logic byte_parity(input logic [7:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/bram_out_pipe.sv
// rtl/bram_out_pipe.sv - read-return staging (1 or 2 registers) with valid pulse and data hold
module bram_out_pipe #(
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  logic          s1_valid_q, s1_valid_d;
  logic [DW-1:0] s1_data_q, s1_data_d;

  always_comb begin
    s1_valid_d = i_valid;
    s1_data_d  = i_valid ? i_data : s1_data_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic          s2_valid_q, s2_valid_d;
    logic [DW-1:0] s2_data_q, s2_data_d;

    always_comb begin
      s2_valid_d = s1_valid_q;
      s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s2_valid_d;
        s2_data_q  <= s2_data_d;
      end
    end

    assign o_valid = s2_valid_q;
    assign o_data  = s2_data_q;
  end else begin : g_lat1
    assign o_valid = s1_valid_q;
    assign o_data  = s1_data_q;
  end

endmodule

// File: rtl/bram_dp_be.sv
// rtl/bram_dp_be.sv - dual-port BRAM: port A read/write with byte enables, port B read-only
// Optional macro BRAM_DP_PARITY_EN adds per-byte even parity storage and o_a_perr/o_b_perr.
module bram_dp_be
  import bram_pkg::*;
#(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int RD_LAT   = 1,
  parameter int WR_FIRST = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [AW-1:0]     i_a_addr,
  input  logic              i_a_en,
  input  logic [DW/8-1:0]   i_a_we,
  input  logic [DW-1:0]     i_a_data,
  output logic [DW-1:0]     o_a_data,
  output logic              o_a_valid,
  input  logic [AW-1:0]     i_b_addr,
  input  logic              i_b_en,
  output logic [DW-1:0]     o_b_data,
`ifdef BRAM_DP_PARITY_EN
  output logic [DW/8-1:0]   o_a_perr,
  output logic [DW/8-1:0]   o_b_perr,
`endif
  output logic              o_b_valid
);

  localparam int       BW    = bw_of(DW);
  localparam int       DEPTH = 1 << AW;
  localparam rw_mode_e MODE  = (WR_FIRST != 0) ? WRITE_FIRST : READ_FIRST;
`ifdef BRAM_DP_PARITY_EN
  localparam int       MW    = DW + BW;
`else
  localparam int       MW    = DW;
`endif

  if (AW < 1 || DW < 8 || (DW % 8) != 0 || !(RD_LAT == 1 || RD_LAT == 2) ||
      !(WR_FIRST == 0 || WR_FIRST == 1)) begin : g_param_check
    $error("bram_dp_be: illegal parameter combination");
  end

  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] a_rd_word, b_rd_word, a_wr_word;
  logic [DW-1:0] a_merged, a_ret_data, b_ret_data;
  logic [BW-1:0] a_byp, b_byp;
  logic          a_wr, b_hit;
  logic [MW-1:0] a_payload, b_payload, a_out, b_out;

  // Bypass masks mark bytes returned straight from i_a_data instead of the array.
  always_comb begin
    a_rd_word  = mem[i_a_addr];
    b_rd_word  = mem[i_b_addr];
    a_wr       = i_a_en && (|i_a_we);
    b_hit      = a_wr && (i_a_addr == i_b_addr) && (MODE == WRITE_FIRST);
    a_byp      = (a_wr && (MODE == WRITE_FIRST)) ? i_a_we : '0;
    b_byp      = b_hit ? i_a_we : '0;
    a_merged   = '0;
    b_ret_data = '0;
    for (int k = 0; k < BW; k++) begin
      a_merged[8*k +: 8]   = byte_merge(a_rd_word[8*k +: 8], i_a_data[8*k +: 8], i_a_we[k]);
      b_ret_data[8*k +: 8] = byte_merge(b_rd_word[8*k +: 8], i_a_data[8*k +: 8], b_byp[k]);
    end
    a_ret_data = (|a_byp) ? a_merged : a_rd_word[DW-1:0];
  end

`ifdef BRAM_DP_PARITY_EN
  logic [BW-1:0] wr_par, a_perr, b_perr;

  always_comb begin
    wr_par = '0;
    a_perr = '0;
    b_perr = '0;
    for (int k = 0; k < BW; k++) begin
      wr_par[k] = i_a_we[k] ? byte_parity(i_a_data[8*k +: 8]) : a_rd_word[DW+k];
      a_perr[k] = (a_rd_word[DW+k] ^ byte_parity(a_rd_word[8*k +: 8])) & ~a_byp[k];
      b_perr[k] = (b_rd_word[DW+k] ^ byte_parity(b_rd_word[8*k +: 8])) & ~b_byp[k];
    end
  end

  assign a_wr_word = {wr_par, a_merged};
  assign a_payload = {a_perr, a_ret_data};
  assign b_payload = {b_perr, b_ret_data};
  assign o_a_perr  = a_out[DW +: BW];
  assign o_b_perr  = b_out[DW +: BW];
`else
  assign a_wr_word = a_merged;
  assign a_payload = a_ret_data;
  assign b_payload = b_ret_data;
`endif

  assign o_a_data = a_out[DW-1:0];
  assign o_b_data = b_out[DW-1:0];

  // Array is deliberately outside the reset domain; reset only blocks the write.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && a_wr) begin
      mem[i_a_addr] <= a_wr_word;
    end
  end

  bram_out_pipe #(.DW(MW), .RD_LAT(RD_LAT)) u_a_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_a_en),
    .i_data  (a_payload),
    .o_valid (o_a_valid),
    .o_data  (a_out)
  );

  bram_out_pipe #(.DW(MW), .RD_LAT(RD_LAT)) u_b_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_b_en),
    .i_data  (b_payload),
    .o_valid (o_b_valid),
    .o_data  (b_out)
  );

endmodule

// File: tb/tb_bram_dp_be.sv
// tb/tb_bram_dp_be.sv - self-checking bench: read-first/lat1 and write-first/lat2 instances side by side
`timescale 1ns/1ps
module tb_bram_dp_be;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [AW-1:0] b_addr = '0;
  logic          a_en   = 1'b0;
  logic          b_en   = 1'b0;
  logic [BW-1:0] a_we   = '0;
  logic [DW-1:0] a_data = '0;
  logic [1:0]    a_v, b_v;
  logic [1:0][DW-1:0] a_q, b_q;
`ifdef BRAM_DP_PARITY_EN
  logic [1:0][BW-1:0] a_pe, b_pe;
`endif

  always #5 clk = ~clk;

  bram_dp_be #(.AW(AW), .DW(DW), .RD_LAT(1), .WR_FIRST(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_addr(a_addr), .i_a_en(a_en), .i_a_we(a_we), .i_a_data(a_data),
    .o_a_data(a_q[0]), .o_a_valid(a_v[0]),
    .i_b_addr(b_addr), .i_b_en(b_en), .o_b_data(b_q[0]),
`ifdef BRAM_DP_PARITY_EN
    .o_a_perr(a_pe[0]), .o_b_perr(b_pe[0]),
`endif
    .o_b_valid(b_v[0])
  );

  bram_dp_be #(.AW(AW), .DW(DW), .RD_LAT(2), .WR_FIRST(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_addr(a_addr), .i_a_en(a_en), .i_a_we(a_we), .i_a_data(a_data),
    .o_a_data(a_q[1]), .o_a_valid(a_v[1]),
    .i_b_addr(b_addr), .i_b_en(b_en), .o_b_data(b_q[1]),
`ifdef BRAM_DP_PARITY_EN
    .o_a_perr(a_pe[1]), .o_b_perr(b_pe[1]),
`endif
    .o_b_valid(b_v[1])
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: flat word array plus a time-stamped delivery schedule per instance/port.
  logic [DW-1:0] mem_m  [DEPTH];
  logic [BW-1:0] flip_m [DEPTH];
  logic          sv [2][2][4];
  logic [DW-1:0] sd [2][2][4];
  logic [BW-1:0] sp [2][2][4];
  logic [DW-1:0] hd [2][2];
  logic [BW-1:0] hp [2][2];
  int            ecnt = 0;

  typedef struct {
    logic          a_en;
    logic [BW-1:0] a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          b_en;
    logic [AW-1:0] b_addr;
    logic          chk;
    logic [DW-1:0] exp0;
    logic [DW-1:0] exp1;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mask_of(input logic [BW-1:0] we);
    logic [DW-1:0] m = '0;
    for (int k = 0; k < BW; k++) if (we[k]) m[8*k +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic sched(input int c, input int p, input logic [DW-1:0] d, input logic [BW-1:0] pe);
    int lat  = c + 1;
    int slot = (ecnt + lat - 1) % 4;
    sv[c][p][slot] = 1'b1;
    sd[c][p][slot] = d;
    sp[c][p][slot] = pe;
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++)
      for (int p = 0; p < 2; p++) begin
        hd[c][p] = '0;
        hp[c][p] = '0;
        for (int s = 0; s < 4; s++) begin
          sv[c][p][s] = 1'b0;
          sd[c][p][s] = '0;
          sp[c][p][s] = '0;
        end
      end
  endtask

  // Instance c=1 is write-first: writes return, and colliding B reads see, the merged word.
  task automatic model_edge();
    logic [DW-1:0] old_a, old_b, m, merged;
    logic          wr, hit, wf;
    if (rst_n) begin
      old_a  = mem_m[a_addr];
      old_b  = mem_m[b_addr];
      m      = mask_of(a_we);
      merged = (old_a & ~m) | (a_data & m);
      wr     = a_en && (a_we != '0);
      hit    = wr && (a_addr == b_addr);
      for (int c = 0; c < 2; c++) begin
        wf = (c == 1);
        if (a_en) sched(c, 0, (wr && wf) ? merged : old_a, flip_m[a_addr] & ~((wr && wf) ? a_we : '0));
        if (b_en) sched(c, 1, (hit && wf) ? merged : old_b, flip_m[b_addr] & ~((hit && wf) ? a_we : '0));
      end
      if (wr) begin
        mem_m[a_addr]  = merged;
        flip_m[a_addr] = flip_m[a_addr] & ~a_we;
      end
    end
    ecnt++;
  endtask

  task automatic check_outputs();
    int s = (ecnt - 1) % 4;
    logic          ev;
    logic          av;
    logic [DW-1:0] ad;
    for (int c = 0; c < 2; c++)
      for (int p = 0; p < 2; p++) begin
        ev = sv[c][p][s];
        if (ev) begin
          hd[c][p] = sd[c][p][s];
          hp[c][p] = sp[c][p][s];
        end
        sv[c][p][s] = 1'b0;
        av = (p == 0) ? a_v[c] : b_v[c];
        ad = (p == 0) ? a_q[c] : b_q[c];
        chk($sformatf("dut%0d_%s_valid_e%0d", c, (p == 0) ? "a" : "b", ecnt), av, ev);
        chk($sformatf("dut%0d_%s_data_e%0d", c, (p == 0) ? "a" : "b", ecnt), ad, hd[c][p]);
`ifdef BRAM_DP_PARITY_EN
        chk($sformatf("dut%0d_%s_perr_e%0d", c, (p == 0) ? "a" : "b", ecnt),
            (p == 0) ? a_pe[c] : b_pe[c], hp[c][p]);
`endif
      end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input logic ae, input logic [BW-1:0] we, input logic [AW-1:0] aa,
                       input logic [DW-1:0] ad, input logic be, input logic [AW-1:0] ba);
    a_en = ae; a_we = we; a_addr = aa; a_data = ad; b_en = be; b_addr = ba;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i]  = '0;
      flip_m[i] = '0;
    end
    model_reset();

    vecs[0] = '{1'b0, 4'h0, 10'h000, 32'h0000_0000, 1'b1, 10'h005, 1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[1] = '{1'b1, 4'hF, 10'h010, 32'hDEAD_BEEF, 1'b0, 10'h000, 1'b0, 32'h0, 32'h0};
    vecs[2] = '{1'b1, 4'h5, 10'h010, 32'h1122_3344, 1'b0, 10'h000, 1'b0, 32'h0, 32'h0};
    vecs[3] = '{1'b0, 4'h0, 10'h000, 32'h0000_0000, 1'b1, 10'h010, 1'b1, 32'hDE22_BE44, 32'hDE22_BE44};
    vecs[4] = '{1'b1, 4'hF, 10'h020, 32'h1234_5678, 1'b0, 10'h000, 1'b0, 32'h0, 32'h0};
    vecs[5] = '{1'b1, 4'hF, 10'h020, 32'hAAAA_AAAA, 1'b1, 10'h020, 1'b1, 32'h1234_5678, 32'hAAAA_AAAA};
    vecs[6] = '{1'b1, 4'h4, 10'h020, 32'h0055_0000, 1'b1, 10'h020, 1'b1, 32'hAAAA_AAAA, 32'hAA55_AAAA};
    vecs[7] = '{1'b0, 4'h0, 10'h000, 32'h0000_0000, 1'b1, 10'h020, 1'b1, 32'hAA55_AAAA, 32'hAA55_AAAA};

    // Enables are asserted during reset and must be ignored.
    drive(1'b1, 4'hF, 10'h005, 32'hFFFF_FFFF, 1'b1, 10'h005);
    repeat (2) step();
    chk("reset_valids", {a_v, b_v}, 4'b0000);
    chk("reset_data", {a_q, b_q}, 128'h0);
    idle();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].a_en, vecs[i].a_we, vecs[i].a_addr, vecs[i].a_data, vecs[i].b_en, vecs[i].b_addr);
      step();
      idle();
      step();
      if (vecs[i].chk) begin
        chk($sformatf("vec%0d_dut0_b", i), b_q[0], vecs[i].exp0);
        chk($sformatf("vec%0d_dut1_b", i), b_q[1], vecs[i].exp1);
      end
    end

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'hF, AW'(i), 32'h1000 + i, 1'b0, '0);
      step();
    end
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(1'b0, '0, '0, '0, 1'b1, AW'(k));
      else idle();
      step();
      chk($sformatf("burst_dut1_valid_%0d", k), b_v[1], (k >= 1 && k <= 4));
      chk($sformatf("burst_dut0_valid_%0d", k), b_v[0], (k <= 3));
      if (k >= 1 && k <= 4) chk($sformatf("burst_dut1_data_%0d", k), b_q[1], 32'h1000 + k - 1);
    end

    drive(1'b1, '0, 10'h010, '0, 1'b0, '0);
    @(posedge clk);
    model_edge();
    #1 rst_n = 1'b0;
    model_reset();
    drive(1'b1, 4'hF, 10'h010, 32'hFFFF_FFFF, 1'b1, 10'h010);
    @(negedge clk);
    check_outputs();
    chk("midrst_dut1_a_valid", a_v[1], 1'b0);
    repeat (2) begin
      step();
      chk("midrst_hold_dut1_a_valid", a_v[1], 1'b0);
    end
    idle();
    rst_n = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b1, 10'h010);
    step();
    idle();
    step();
    chk("postrst_dut0_b", b_q[0], 32'hDE22_BE44);
    chk("postrst_dut1_b", b_q[1], 32'hDE22_BE44);

`ifdef BRAM_DP_PARITY_EN
    drive(1'b1, 4'hF, 10'h030, 32'h0102_0304, 1'b0, '0);
    step();
    idle();
    step();
    dut0.mem[10'h030][DW+2] = ~dut0.mem[10'h030][DW+2];
    dut1.mem[10'h030][DW+2] = ~dut1.mem[10'h030][DW+2];
    flip_m[10'h030][2] = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b1, 10'h030);
    step();
    chk("parity_dut0_valid", b_v[0], 1'b1);
    chk("parity_dut0_perr", b_pe[0], 4'b0100);
    idle();
    step();
    chk("parity_dut1_valid", b_v[1], 1'b1);
    chk("parity_dut1_perr", b_pe[1], 4'b0100);
`endif

    for (int i = 0; i < 400; i++) begin
      a_en   = 1'($urandom_range(0, 1));
      a_we   = ($urandom_range(0, 3) == 0) ? '0 : BW'($urandom);
      a_addr = AW'($urandom_range(0, 15));
      a_data = $urandom;
      b_en   = 1'($urandom_range(0, 1));
      b_addr = ($urandom_range(0, 2) == 0) ? a_addr : AW'($urandom_range(0, 15));
      step();
    end
    idle();
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
